// File: rtl/wb_write_queue_pkg.sv
// Shared definitions for the writeback write queue.
//   DATA_W_DEF / ADDR_W_DEF : default register data and index widths
//   NUM_REGS                : register count for the default index width
//   wb_entry_t              : one queued register write {rd, data}
//   occ_width()             : bits needed to count 0..depth entries
package wb_write_queue_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 2;
  localparam int NUM_REGS   = 1 << ADDR_W_DEF;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] data;
  } wb_entry_t;

  // One extra bit over the pointer width so "full" is representable.
  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Combinational youngest-match search over the queued writes.
//   vld      : per-slot valid, slot 0 is the oldest (head) entry
//   rd_arr   : destination register per slot
//   data_arr : value per slot
//   q        : register being looked up
//   hit/data : youngest matching entry; 0/0 when nothing matches
module wb_fwd_lookup #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic [DEPTH-1:0]  vld,
  input  logic [ADDR_W-1:0] rd_arr   [DEPTH],
  input  logic [DATA_W-1:0] data_arr [DEPTH],
  input  logic [ADDR_W-1:0] q,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  // Slots are age-ordered, so a later match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (vld[k] && (rd_arr[k] == q)) begin
        hit  = 1'b1;
        data = data_arr[k];
      end
    end
  end

endmodule

// File: rtl/wb_write_queue.sv
// In-order queue between the WB stage and the register file write port.
//   in_*        : result handshake from WB (in_ready = not full)
//   flush       : synchronous clear, also discards a same-cycle push
//   wb_hold     : blocks draining this cycle
//   rf_*        : register file write port, one write per cycle
//   q_rs / q_rt : forwarding queries, answered from queued entries only
//   pending     : per-register "write still queued" scoreboard
//   occupancy   : number of valid entries
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_reg_write,
  input  logic [ADDR_W-1:0]            in_rd,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         flush,
  input  logic                         wb_hold,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_rd,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [ADDR_W-1:0]            q_rs,
  input  logic [ADDR_W-1:0]            q_rt,
  output logic                         fwd_rs_hit,
  output logic [DATA_W-1:0]            fwd_rs_data,
  output logic                         fwd_rt_hit,
  output logic [DATA_W-1:0]            fwd_rt_data,
  output logic [(1<<ADDR_W)-1:0]       pending,
  output logic [occ_width(DEPTH)-1:0]  occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = occ_width(DEPTH);

  logic [ADDR_W-1:0] rd_mem   [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic [OCC_W-1:0]  count;

  logic full, empty, push, pop;

  // Age-ordered view of the storage: slot 0 is the head.
  logic [DEPTH-1:0]  age_vld;
  logic [ADDR_W-1:0] age_rd   [DEPTH];
  logic [DATA_W-1:0] age_data [DEPTH];

  assign full  = (count == OCC_W'(DEPTH));
  assign empty = (count == '0);

  // in_ready looks only at full so nothing on the drain side feeds back
  // combinationally into the WB handshake.
  assign in_ready = !full;
  assign push     = in_valid && in_ready && in_reg_write && !flush;
  assign pop      = rf_we;

  assign rf_we    = !empty && !wb_hold && !flush;
  assign rf_rd    = empty ? '0 : rd_mem[head];
  assign rf_wdata = empty ? '0 : data_mem[head];

  assign occupancy = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage needs no reset: every read is qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[tail]   <= in_rd;
      data_mem[tail] <= in_data;
    end
  end

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      age_vld[k]  = (OCC_W'(k) < count);
      age_rd[k]   = rd_mem[head + PTR_W'(k)];
      age_data[k] = data_mem[head + PTR_W'(k)];
    end
  end

  always_comb begin
    pending = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_vld[k]) pending[age_rd[k]] = 1'b1;
    end
  end

  wb_fwd_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rs (
    .vld      (age_vld),
    .rd_arr   (age_rd),
    .data_arr (age_data),
    .q        (q_rs),
    .hit      (fwd_rs_hit),
    .data     (fwd_rs_data)
  );

  wb_fwd_lookup #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd_rt (
    .vld      (age_vld),
    .rd_arr   (age_rd),
    .data_arr (age_data),
    .q        (q_rt),
    .hit      (fwd_rt_hit),
    .data     (fwd_rt_data)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_reg_write;
  logic [1:0] in_rd;
  logic [7:0] in_data;
  logic       flush, wb_hold;
  logic       rf_we;
  logic [1:0] rf_rd;
  logic [7:0] rf_wdata;
  logic [1:0] q_rs, q_rt;
  logic       fwd_rs_hit, fwd_rt_hit;
  logic [7:0] fwd_rs_data, fwd_rt_data;
  logic [3:0] pending;
  logic [1:0] occupancy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(2), .DATA_W(8), .ADDR_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_reg_write (in_reg_write),
    .in_rd        (in_rd),
    .in_data      (in_data),
    .flush        (flush),
    .wb_hold      (wb_hold),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .q_rs         (q_rs),
    .q_rt         (q_rt),
    .fwd_rs_hit   (fwd_rs_hit),
    .fwd_rs_data  (fwd_rs_data),
    .fwd_rt_hit   (fwd_rt_hit),
    .fwd_rt_data  (fwd_rt_data),
    .pending      (pending),
    .occupancy    (occupancy)
  );

  typedef struct {
    logic       vld, rw;
    logic [1:0] rd;
    logic [7:0] d;
    logic       fl, hold;
    logic [1:0] qs, qt;
    logic       e_rdy, e_we;
    logic [1:0] e_rd;
    logic [7:0] e_wd;
    logic       e_sh;
    logic [7:0] e_sd;
    logic       e_th;
    logic [7:0] e_td;
    logic [3:0] e_pend;
    logic [1:0] e_occ;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] rd, input logic [7:0] d,
                       input logic fl, input logic hold, input logic [1:0] qs, input logic [1:0] qt);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_data = d;
    flush = fl; wb_hold = hold; q_rs = qs; q_rt = qt;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    //          vld rw rd d      fl hold qs qt | rdy we rd wd     sh sd     th td     pend     occ
    vt[0]  = '{0, 0, 0, 8'h00, 0, 0, 2, 1,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[1]  = '{1, 1, 2, 8'h5A, 0, 0, 2, 1,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[2]  = '{0, 0, 0, 8'h00, 0, 0, 2, 1,   1, 1, 2, 8'h5A, 1, 8'h5A, 0, 8'h00, 4'b0100, 1};
    vt[3]  = '{0, 0, 0, 8'h00, 0, 0, 2, 1,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[4]  = '{1, 1, 1, 8'h11, 0, 1, 1, 2,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[5]  = '{1, 1, 1, 8'h22, 0, 1, 1, 2,   1, 0, 1, 8'h11, 1, 8'h11, 0, 8'h00, 4'b0010, 1};
    vt[6]  = '{1, 1, 3, 8'h33, 0, 1, 1, 2,   0, 0, 1, 8'h11, 1, 8'h22, 0, 8'h00, 4'b0010, 2};
    vt[7]  = '{0, 0, 0, 8'h00, 0, 0, 1, 2,   0, 1, 1, 8'h11, 1, 8'h22, 0, 8'h00, 4'b0010, 2};
    vt[8]  = '{0, 0, 0, 8'h00, 0, 0, 1, 2,   1, 1, 1, 8'h22, 1, 8'h22, 0, 8'h00, 4'b0010, 1};
    vt[9]  = '{0, 0, 0, 8'h00, 0, 0, 1, 3,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[10] = '{1, 0, 3, 8'hFF, 0, 0, 3, 3,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};
    vt[11] = '{0, 0, 0, 8'h00, 0, 0, 3, 3,   1, 0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 4'b0000, 0};

    rst_n = 1'b0;
    drive(1, 1, 2, 8'hAA, 0, 0, 2, 2);
    @(negedge clk);
    chk("rst_ready", in_ready, 1);
    chk("rst_we", rf_we, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_pend", pending, 0);
    chk("rst_rs_hit", fwd_rs_hit, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      drive(vt[i].vld, vt[i].rw, vt[i].rd, vt[i].d, vt[i].fl, vt[i].hold, vt[i].qs, vt[i].qt);
      @(negedge clk);
      chk($sformatf("v%0d_ready", i), in_ready, vt[i].e_rdy);
      chk($sformatf("v%0d_we", i), rf_we, vt[i].e_we);
      chk($sformatf("v%0d_rd", i), rf_rd, vt[i].e_rd);
      chk($sformatf("v%0d_wdata", i), rf_wdata, vt[i].e_wd);
      chk($sformatf("v%0d_rs_hit", i), fwd_rs_hit, vt[i].e_sh);
      chk($sformatf("v%0d_rs_data", i), fwd_rs_data, vt[i].e_sd);
      chk($sformatf("v%0d_rt_hit", i), fwd_rt_hit, vt[i].e_th);
      chk($sformatf("v%0d_rt_data", i), fwd_rt_data, vt[i].e_td);
      chk($sformatf("v%0d_pend", i), pending, vt[i].e_pend);
      chk($sformatf("v%0d_occ", i), occupancy, vt[i].e_occ);
    end

    // Streaming: push every cycle while draining; head lags by one cycle.
    for (int i = 0; i <= 11; i++) begin
      @(posedge clk); #1;
      if (i < 10) drive(1, 1, 2'(i % 4), 8'(i), 0, 0, 0, 0);
      else        drive(0, 0, 0, 8'h00, 0, 0, 0, 0);
      @(negedge clk);
      if (i == 0 || i == 11) begin
        chk($sformatf("st%0d_we", i), rf_we, 0);
        chk($sformatf("st%0d_occ", i), occupancy, 0);
      end else begin
        chk($sformatf("st%0d_we", i), rf_we, 1);
        chk($sformatf("st%0d_rd", i), rf_rd, (i - 1) % 4);
        chk($sformatf("st%0d_wdata", i), rf_wdata, i - 1);
        chk($sformatf("st%0d_occ", i), occupancy, 1);
      end
    end

    // Flush with two queued entries and a concurrent push attempt.
    @(posedge clk); #1; drive(1, 1, 0, 8'hA0, 0, 1, 0, 3);
    @(posedge clk); #1; drive(1, 1, 3, 8'hB3, 0, 1, 0, 3);
    @(negedge clk);
    chk("fl_occ_pre", occupancy, 1);
    @(posedge clk); #1; drive(1, 1, 2, 8'hC2, 1, 0, 0, 3);
    @(negedge clk);
    chk("fl_we", rf_we, 0);
    chk("fl_occ", occupancy, 2);
    chk("fl_pend", pending, 4'b1001);
    chk("fl_rs_hit", fwd_rs_hit, 1);
    chk("fl_rs_data", fwd_rs_data, 8'hA0);
    chk("fl_rt_hit", fwd_rt_hit, 1);
    chk("fl_rt_data", fwd_rt_data, 8'hB3);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1; drive(0, 0, 0, 8'h00, 0, 0, 0, 3);
      @(negedge clk);
      chk($sformatf("fl_after%0d_we", i), rf_we, 0);
      chk($sformatf("fl_after%0d_occ", i), occupancy, 0);
      chk($sformatf("fl_after%0d_pend", i), pending, 0);
    end

    // Flush with room in the queue: the same-cycle push must be dropped.
    @(posedge clk); #1; drive(1, 1, 1, 8'h77, 0, 1, 2, 1);
    @(posedge clk); #1; drive(1, 1, 2, 8'h88, 1, 1, 2, 1);
    @(negedge clk);
    chk("fl2_occ", occupancy, 1);
    chk("fl2_rt_data", fwd_rt_data, 8'h77);
    @(posedge clk); #1; drive(0, 0, 0, 8'h00, 0, 0, 2, 1);
    @(negedge clk);
    chk("fl2_after_occ", occupancy, 0);
    chk("fl2_after_pend", pending, 0);
    chk("fl2_after_rs_hit", fwd_rs_hit, 0);
    chk("fl2_after_we", rf_we, 0);

    // Asynchronous reset mid-cycle with two queued entries.
    @(posedge clk); #1; drive(1, 1, 1, 8'h44, 0, 1, 1, 2);
    @(posedge clk); #1; drive(1, 1, 2, 8'h55, 0, 1, 1, 2);
    @(posedge clk); #1; drive(0, 0, 0, 8'h00, 0, 0, 1, 2);
    @(negedge clk);
    chk("ar_pre_we", rf_we, 1);
    chk("ar_pre_occ", occupancy, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_we", rf_we, 0);
    chk("ar_rd", rf_rd, 0);
    chk("ar_wdata", rf_wdata, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_occ", occupancy, 0);
    chk("ar_pend", pending, 0);
    chk("ar_rs_hit", fwd_rs_hit, 0);
    chk("ar_rs_data", fwd_rs_data, 0);
    chk("ar_rt_hit", fwd_rt_hit, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      @(negedge clk);
      chk($sformatf("ar_after%0d_we", i), rf_we, 0);
      chk($sformatf("ar_after%0d_occ", i), occupancy, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
